// File: rtl/semaforo_sensores_pkg.sv
`default_nettype none
// ============================================================================
// Module   : semaforo_sensores_pkg
// Brief    : Shared types and helpers for the traffic-light sensor front-end.
//            Channel state encoding matches the light controller's constants.
// Revision : 1.0 - initial release
// ============================================================================
package semaforo_sensores_pkg;

   // Channel FSM encoding, kept identical to the light controller's copy
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      PRESENT = 2'd2,
      HOLD    = 2'd3
   } canal_state_t;

   // Bits needed for a counter that must reach max(a, b)
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_canal.sv
`default_nettype none
// ============================================================================
// Module   : sensor_canal
// Brief    : One detector channel: 2-flop synchroniser, debounce/hold FSM with
//            registered outputs, and a saturating vehicle counter.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_canal
   import semaforo_sensores_pkg::*;
#(
   parameter int DEB_CYCLES  = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               car_raw,
   input  logic               clr_counts,
   output logic               present,
   output logic               evt,
   output logic [COUNT_W-1:0] count
);

   localparam int c_cnt_w = cnt_width(DEB_CYCLES, HOLD_CYCLES);
   localparam logic [c_cnt_w-1:0] c_deb  = c_cnt_w'(DEB_CYCLES);
   localparam logic [c_cnt_w-1:0] c_hold = c_cnt_w'(HOLD_CYCLES);
   localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
   localparam logic [COUNT_W-1:0] c_count_max = {COUNT_W{1'b1}};

   logic               r_sync1;
   logic               r_sync2;
   canal_state_t       r_state;
   canal_state_t       w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic               r_present;
   logic               w_present_nxt;
   logic               r_evt;
   logic               w_evt_nxt;
   logic [COUNT_W-1:0] r_count;

   // Two-flop synchroniser for the asynchronous detector input
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= car_raw;
         r_sync2 <= r_sync1;
      end
   end

   // State, window counter and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_present <= 1'b0;
         r_evt     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_present <= w_present_nxt;
         r_evt     <= w_evt_nxt;
      end
   end

   // Next-state logic: debounce on the way in, hold time on the way out
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_evt_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_sync2) begin
               w_state_nxt = CONFIRM;
               w_cnt_nxt   = c_one;
            end
         end
         CONFIRM: begin
            if (!r_sync2) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == c_deb) begin
               w_state_nxt = PRESENT;
               w_evt_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         PRESENT: begin
            if (!r_sync2) begin
               w_state_nxt = HOLD;
               w_cnt_nxt   = c_one;
            end
         end
         HOLD: begin
            // Returning detector resumes the same vehicle, no new event
            if (r_sync2) begin
               w_state_nxt = PRESENT;
            end else if (r_cnt == c_hold) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_present_nxt = (w_state_nxt == PRESENT) || (w_state_nxt == HOLD);
   end

   // Saturating vehicle counter; clear has priority over a coincident event
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clr_counts) begin
         r_count <= '0;
      end else if (w_evt_nxt && (r_count != c_count_max)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign present = r_present;
   assign evt     = r_evt;
   assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/semaforo_sensores.sv
`default_nettype none
// ============================================================================
// Module   : semaforo_sensores
// Brief    : Two-street sensor front-end producing TA/TB for the light
//            controller plus per-street vehicle events and counts.
// Revision : 1.0 - initial release
// ============================================================================
module semaforo_sensores
   import semaforo_sensores_pkg::*;
#(
   parameter int DEB_CYCLES  = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               car_a_raw,
   input  logic               car_b_raw,
   input  logic               clr_counts,
   output logic               TA,
   output logic               TB,
   output logic               evt_a,
   output logic               evt_b,
   output logic [COUNT_W-1:0] count_a,
   output logic [COUNT_W-1:0] count_b
);

   // Street A channel
   sensor_canal #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .COUNT_W     (COUNT_W)
   ) u_canal_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .car_raw    (car_a_raw),
      .clr_counts (clr_counts),
      .present    (TA),
      .evt        (evt_a),
      .count      (count_a)
   );

   // Street B channel
   sensor_canal #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .COUNT_W     (COUNT_W)
   ) u_canal_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .car_raw    (car_b_raw),
      .clr_counts (clr_counts),
      .present    (TB),
      .evt        (evt_b),
      .count      (count_b)
   );

endmodule
`default_nettype wire

// File: tb/tb_semaforo_sensores.sv
`default_nettype none
// ============================================================================
// Module   : tb_semaforo_sensores
// Brief    : Directed self-checking bench for semaforo_sensores (default
//            parameters plus a COUNT_W=2 instance for saturation).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_semaforo_sensores;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       car_a_raw = 1'b0;
   logic       car_b_raw = 1'b0;
   logic       clr_counts = 1'b0;
   logic       TA, TB, evt_a, evt_b;
   logic [7:0] count_a, count_b;
   logic       ta2, tb2, evt_a2, evt_b2;
   logic [1:0] count_a2, count_b2;

   int errors = 0;
   int checks = 0;

   semaforo_sensores dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .car_a_raw  (car_a_raw),
      .car_b_raw  (car_b_raw),
      .clr_counts (clr_counts),
      .TA         (TA),
      .TB         (TB),
      .evt_a      (evt_a),
      .evt_b      (evt_b),
      .count_a    (count_a),
      .count_b    (count_b)
   );

   semaforo_sensores #(.COUNT_W(2)) dut2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .car_a_raw  (car_a_raw),
      .car_b_raw  (car_b_raw),
      .clr_counts (clr_counts),
      .TA         (ta2),
      .TB         (tb2),
      .evt_a      (evt_a2),
      .evt_b      (evt_b2),
      .count_a    (count_a2),
      .count_b    (count_b2)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({TA, TB, evt_a, evt_b, count_a, count_b} !== 20'd0) begin
         errors++;
         $display("FAIL reset_immediate: got TA=%b TB=%b ea=%b eb=%b ca=%0d cb=%0d want all 0",
                  TA, TB, evt_a, evt_b, count_a, count_b);
      end
      for (int i = 0; i < 6; i++) begin
         car_a_raw = i[0];
         car_b_raw = ~i[0];
         step();
         checks++;
         if ({TA, TB, evt_a, evt_b, count_a, count_b} !== 20'd0) begin
            errors++;
            $display("FAIL reset_hold cyc%0d: got TA=%b TB=%b ea=%b eb=%b ca=%0d cb=%0d want all 0",
                     i, TA, TB, evt_a, evt_b, count_a, count_b);
         end
      end
      car_a_raw = 1'b0;
      car_b_raw = 1'b0;
      reset_n   = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if ({TA, TB, evt_a, evt_b, count_a, count_b} !== 20'd0) begin
            errors++;
            $display("FAIL post_reset cyc%0d: got TA=%b TB=%b ea=%b eb=%b ca=%0d cb=%0d want all 0",
                     i, TA, TB, evt_a, evt_b, count_a, count_b);
         end
      end
   endtask

   task automatic test_single_a();
      logic       exp_t, exp_e;
      logic [7:0] exp_c;
      car_a_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         exp_t = (i >= 6);
         exp_e = (i == 6);
         exp_c = (i >= 6) ? 8'd1 : 8'd0;
         checks++;
         if (TA !== exp_t || evt_a !== exp_e || count_a !== exp_c || TB !== 1'b0 || evt_b !== 1'b0) begin
            errors++;
            $display("FAIL single_rise edge%0d: got TA=%b ea=%b ca=%0d TB=%b eb=%b want TA=%b ea=%b ca=%0d TB=0 eb=0",
                     i, TA, evt_a, count_a, TB, evt_b, exp_t, exp_e, exp_c);
         end
      end
      car_a_raw = 1'b0;
      for (int j = 0; j < 12; j++) begin
         step();
         exp_t = (j < 10);
         checks++;
         if (TA !== exp_t || evt_a !== 1'b0 || count_a !== 8'd1 || TB !== 1'b0) begin
            errors++;
            $display("FAIL single_fall edge%0d: got TA=%b ea=%b ca=%0d TB=%b want TA=%b ea=0 ca=1 TB=0",
                     j, TA, evt_a, count_a, TB, exp_t);
         end
      end
   endtask

   task automatic test_glitch_b();
      car_b_raw = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i == 3) car_b_raw = 1'b0;
         step();
         checks++;
         if (TB !== 1'b0 || evt_b !== 1'b0) begin
            errors++;
            $display("FAIL glitch_b edge%0d: got TB=%b eb=%b want TB=0 eb=0", i, TB, evt_b);
         end
      end
      checks++;
      if (count_b !== 8'd0) begin
         errors++;
         $display("FAIL glitch_b_count: got %0d want 0", count_b);
      end
   endtask

   task automatic test_gap_a();
      logic exp_t, exp_e;
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      checks++;
      if (count_a !== 8'd0) begin
         errors++;
         $display("FAIL gap_clr: got count_a=%0d want 0", count_a);
      end
      for (int i = 0; i < 62; i++) begin
         car_a_raw = (i < 20) || (i >= 25 && i < 45);
         step();
         exp_t = (i >= 6) && (i < 55);
         exp_e = (i == 6);
         checks++;
         if (TA !== exp_t || evt_a !== exp_e) begin
            errors++;
            $display("FAIL gap_bridge edge%0d: got TA=%b ea=%b want TA=%b ea=%b", i, TA, evt_a, exp_t, exp_e);
         end
      end
      checks++;
      if (count_a !== 8'd1) begin
         errors++;
         $display("FAIL gap_count: got count_a=%0d want 1", count_a);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_c;
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      checks++;
      if (count_a2 !== 2'd0) begin
         errors++;
         $display("FAIL sat_clr0: got count_a2=%0d want 0", count_a2);
      end
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 50; i++) begin
            car_a_raw = (i < 20);
            step();
            if (i == 6) begin
               checks++;
               if (evt_a2 !== 1'b1) begin
                  errors++;
                  $display("FAIL sat_evt veh%0d: got evt_a2=%b want 1", v, evt_a2);
               end
            end
         end
         exp_c = (v >= 2) ? 2'd3 : 2'(v + 1);
         checks++;
         if (count_a2 !== exp_c) begin
            errors++;
            $display("FAIL sat_count veh%0d: got count_a2=%0d want %0d", v, count_a2, exp_c);
         end
      end
      checks++;
      if (count_a !== 8'd5) begin
         errors++;
         $display("FAIL wide_count: got count_a=%0d want 5", count_a);
      end
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      checks++;
      if (count_a2 !== 2'd0 || count_a !== 8'd0) begin
         errors++;
         $display("FAIL clr_pulse: got count_a2=%0d count_a=%0d want 0 0", count_a2, count_a);
      end
      // One vehicle to get a nonzero count, then clear on the event edge
      for (int i = 0; i < 50; i++) begin
         car_a_raw = (i < 20);
         step();
      end
      checks++;
      if (count_a2 !== 2'd1) begin
         errors++;
         $display("FAIL clr_pre: got count_a2=%0d want 1", count_a2);
      end
      for (int i = 0; i < 50; i++) begin
         car_a_raw  = (i < 20);
         clr_counts = (i == 6);
         step();
         if (i == 6) begin
            checks++;
            if (evt_a2 !== 1'b1 || count_a2 !== 2'd0 || count_a !== 8'd0 || TA !== 1'b1) begin
               errors++;
               $display("FAIL clr_vs_evt: got evt_a2=%b count_a2=%0d count_a=%0d TA=%b want 1 0 0 1",
                        evt_a2, count_a2, count_a, TA);
            end
         end
      end
      clr_counts = 1'b0;
      checks++;
      if (count_a2 !== 2'd0) begin
         errors++;
         $display("FAIL clr_after: got count_a2=%0d want 0", count_a2);
      end
   endtask

   task automatic test_async_reset();
      logic exp_t, exp_e;
      car_a_raw = 1'b1;
      car_b_raw = 1'b1;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (TA !== 1'b1 || TB !== 1'b1 || count_a !== 8'd1 || count_b !== 8'd1) begin
         errors++;
         $display("FAIL both_present: got TA=%b TB=%b ca=%0d cb=%0d want 1 1 1 1", TA, TB, count_a, count_b);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (TA !== 1'b0 || TB !== 1'b0 || count_a !== 8'd0 || count_b !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got TA=%b TB=%b ca=%0d cb=%0d want 0 0 0 0", TA, TB, count_a, count_b);
      end
      step();
      checks++;
      if (TA !== 1'b0 || TB !== 1'b0 || evt_a !== 1'b0 || evt_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_edge: got TA=%b TB=%b ea=%b eb=%b want 0", TA, TB, evt_a, evt_b);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         exp_t = (i >= 6);
         exp_e = (i == 6);
         checks++;
         if (TA !== exp_t || TB !== exp_t || evt_a !== exp_e || evt_b !== exp_e) begin
            errors++;
            $display("FAIL rerise edge%0d: got TA=%b TB=%b ea=%b eb=%b want T=%b e=%b",
                     i, TA, TB, evt_a, evt_b, exp_t, exp_e);
         end
      end
      checks++;
      if (count_a !== 8'd1 || count_b !== 8'd1) begin
         errors++;
         $display("FAIL rerise_count: got ca=%0d cb=%0d want 1 1", count_a, count_b);
      end
      car_a_raw = 1'b0;
      car_b_raw = 1'b0;
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (TA !== 1'b0 || TB !== 1'b0) begin
         errors++;
         $display("FAIL final_idle: got TA=%b TB=%b want 0 0", TA, TB);
      end
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_glitch_b();
      test_gap_a();
      test_saturate();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/semaforo_sensores.md
Name: semaforo_sensores

Overview:
- Sensor front-end for the two-street traffic-light controller. Produces the controller's TA/TB "traffic present" inputs from raw, asynchronous, bouncy loop-detector signals.
- Per street: synchronise, debounce, and extend presence with a hold time so brief gaps between cars do not toggle the light.
- Also counts vehicles per street for monitoring.
- Sits between the board-level detector pins and the controller's TA/TB inputs.

Parameters:
- DEB_CYCLES, 4: consecutive high synchronised samples needed to confirm a vehicle; legal range >= 1.
- HOLD_CYCLES, 8: cycles TA/TB stay high after the detector clears; legal range >= 1.
- COUNT_W, 8: width of each vehicle counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- car_a_raw  in  1  raw detector, street A; asynchronous to clk.
- car_b_raw  in  1  raw detector, street B; asynchronous to clk.
- clr_counts  in  1  synchronous clear of both counters.
- TA  out  1  traffic present on street A (to the controller).
- TB  out  1  traffic present on street B (to the controller).
- evt_a  out  1  one-cycle pulse per confirmed vehicle, street A.
- evt_b  out  1  one-cycle pulse per confirmed vehicle, street B.
- count_a  out  COUNT_W  confirmed vehicles, street A; saturating.
- count_b  out  COUNT_W  confirmed vehicles, street B; saturating.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Synchronisers cleared, both FSMs in IDLE, internal counters 0.
  - TA=TB=0, evt_a=evt_b=0, count_a=count_b=0.
  - Takes effect immediately, including mid-PRESENT or mid-HOLD.
- Synchroniser: two flops per channel; s = second flop output.
- Channel FSM (identical per channel, all outputs registered). Internal counter cnt is wide enough for max(DEB_CYCLES, HOLD_CYCLES).
  - IDLE: T=0. s=1 -> CONFIRM, cnt<=1.
  - CONFIRM: T=0.
    - s=0 -> IDLE.
    - s=1 and cnt==DEB_CYCLES -> PRESENT; evt pulses for that one cycle; count increments.
    - Otherwise cnt++.
  - PRESENT: T=1. s=0 -> HOLD, cnt<=1.
  - HOLD: T=1.
    - s=1 -> PRESENT; no new event, no count.
    - s=0 and cnt==HOLD_CYCLES -> IDLE.
    - Otherwise cnt++.
- Latency, with raw stable from sampling edge 0:
  - T and evt rise after edge DEB_CYCLES+2.
  - T falls after edge HOLD_CYCLES+2 following the raw fall.
  - Defaults: 6 cycles to rise, 10 cycles to fall.
- Glitch rejection: any raw high pulse shorter than the confirm window produces no T, no evt, no count. A pulse of DEB_CYCLES or fewer cycles is always rejected.
- Gap bridging: a raw gap short enough that s returns high before HOLD expires keeps T continuously high and counts nothing new.
- Counters:
  - Increment by 1 on evt.
  - Saturate at 2^COUNT_W-1; no wrap.
  - clr_counts=1 forces 0 on the next edge; clear wins over a simultaneous evt (that increment is lost).
  - clr_counts does not affect the FSMs, TA/TB or evt.
- Channels are fully independent. Simultaneous events on A and B are both counted.

Decomposition:
- Shared package/header: FSM state encoding (IDLE=2'd0, CONFIRM=2'd1, PRESENT=2'd2, HOLD=2'd3), shared with the light controller's constants file.
- One sub-module, sensor_canal: synchroniser + FSM + saturating counter for one street, with parameters DEB_CYCLES, HOLD_CYCLES, COUNT_W.
- Top instantiates sensor_canal twice (A, B) with shared clk, reset_n and clr_counts.

Test Plan:
1. reset_n=0 at t=3 with raw inputs toggling -> TA=TB=0, evt=0, count_a=count_b=0 throughout reset. After release with raws low, outputs stay 0.
2. car_a_raw=1 for 20 cycles, defaults -> TA=1 and evt_a=1 for exactly one cycle after edge 6; count_a=1. After raw falls, TA=0 after edge 10; TB untouched.
3. car_b_raw high for 3 cycles, then low -> TB never rises, evt_b never pulses, count_b=0.
4. car_a_raw high 20, low 5, high 20 -> TA continuously 1 from first rise until 10 cycles after the final fall; count_a=1.
5. COUNT_W=2, five separate 20-cycle vehicles on A (30-cycle gaps) -> count_a=1,2,3,3,3. clr_counts for 1 cycle -> count_a=0. clr_counts on the same edge as an evt -> count_a=0.
6. Both channels high during PRESENT, then reset_n=0 between clock edges -> TA=TB=0 immediately (asynchronously), counts 0. Release with raws still high -> full DEB_CYCLES+2 latency before TA/TB rise again.
